// File: rtl/mul_sched_if.sv
// EX-stage / ALU multiplier handshake bundle seen by the multiply scheduler.
// Latency: none, plain wires.
// Backpressure: exstall is the pipeline stall; alubusy is the ALU-side hold-off.
// Signals: ex_valid, ex_mul, ex_hilo_rd, ex_flush, ex_hold, alubusy (to scheduler);
//          alugo, exstall (from scheduler).
interface mul_sched_if;
    logic ex_valid;
    logic ex_mul;
    logic ex_hilo_rd;
    logic ex_flush;
    logic ex_hold;
    logic alubusy;
    logic alugo;
    logic exstall;

    // scheduler side
    modport slave (
        input  ex_valid, ex_mul, ex_hilo_rd, ex_flush, ex_hold, alubusy,
        output alugo, exstall
    );

    // pipeline/ALU side
    modport master (
        output ex_valid, ex_mul, ex_hilo_rd, ex_flush, ex_hold, alubusy,
        input  alugo, exstall
    );
endinterface

// File: rtl/mul_sched.sv
// Issue/interlock controller for the ALU HI/LO multiplier, with watchdog and perf counters.
// Latency: alugo/exstall are combinational from inputs (zero cycles); state moves on phi2 edges.
// Backpressure: stalls EX for multiplies and HI/LO reads while the multiplier is not free.
// Ports: clk, rst (sync, active-high), phi2 (advance enable), bus (mul_sched_if.slave),
//        err (sticky watchdog flag), mulcnt (issued multiplies), stallcnt (stalled phi2 cycles).
module mul_sched #(
    parameter int CNTW    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            phi2,
    mul_sched_if.slave      bus,
    output logic            err,
    output logic [CNTW-1:0] mulcnt,
    output logic [CNTW-1:0] stallcnt
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [WDW-1:0] wd, wd_nxt;
    logic           err_set;
    logic           live, free, issue, stall;

    always_comb begin
        live  = bus.ex_valid & ~bus.ex_flush;
        free  = (state == IDLE) | ((state == RUN) & ~bus.alubusy);
        // Reset overrides everything, including a same-cycle issue.
        issue = ~rst & phi2 & free & live & bus.ex_mul & ~bus.ex_hold & ~bus.alubusy;
        stall = ~rst & live & (bus.ex_mul | bus.ex_hilo_rd) & ~free;

        bus.alugo   = issue;
        bus.exstall = stall;

        state_nxt = state;
        wd_nxt    = wd;
        err_set   = 1'b0;
        case (state)
            SYNC: begin
                // ALU has no reset: wait until it reports idle before trusting it.
                if (!bus.alubusy) begin
                    state_nxt = IDLE;
                    wd_nxt    = '0;
                end
            end
            IDLE: begin
                if (issue) begin
                    state_nxt = RUN;
                    wd_nxt    = '0;
                end
            end
            RUN: begin
                if (bus.alubusy) begin
                    if (wd == WDW'(TIMEOUT - 1)) begin
                        // This busy edge is the TIMEOUT-th one: give up and resync.
                        state_nxt = SYNC;
                        wd_nxt    = '0;
                        err_set   = 1'b1;
                    end else begin
                        wd_nxt = wd + 1'b1;
                    end
                end else begin
                    state_nxt = issue ? RUN : IDLE;
                    wd_nxt    = '0;
                end
            end
            default: begin
                state_nxt = SYNC;
                wd_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SYNC;
            wd       <= '0;
            err      <= 1'b0;
            mulcnt   <= '0;
            stallcnt <= '0;
        end else if (phi2) begin
            state <= state_nxt;
            wd    <= wd_nxt;
            if (err_set) begin
                err <= 1'b1;
            end
            // Counters saturate at all-ones.
            if (issue && (mulcnt != {CNTW{1'b1}})) begin
                mulcnt <= mulcnt + 1'b1;
            end
            if (stall && (stallcnt != {CNTW{1'b1}})) begin
                stallcnt <= stallcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: directed scenarios then random traffic, checked against a behavioural model.
// Latency: outputs sampled 1ns after inputs settle and 1ns after each rising edge.
// Backpressure: the bench models the ALU busy window (4 or 7 phi2 cycles, or held indefinitely).
module tb_mul_sched;
    localparam int TO   = 15;
    localparam int M_SY = 0;
    localparam int M_ID = 1;
    localparam int M_RN = 2;

    logic clk = 1'b0;
    logic rst;
    logic phi2;
    always #5 clk = ~clk;

    mul_sched_if ifa ();
    mul_sched_if ifb ();

    logic        err_a, err_b;
    logic [31:0] mc_a, sc_a;
    logic [3:0]  mc_b, sc_b;

    assign ifb.ex_valid   = ifa.ex_valid;
    assign ifb.ex_mul     = ifa.ex_mul;
    assign ifb.ex_hilo_rd = ifa.ex_hilo_rd;
    assign ifb.ex_flush   = ifa.ex_flush;
    assign ifb.ex_hold    = ifa.ex_hold;
    assign ifb.alubusy    = ifa.alubusy;

    mul_sched #(.CNTW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .phi2(phi2), .bus(ifa.slave),
        .err(err_a), .mulcnt(mc_a), .stallcnt(sc_a)
    );

    mul_sched #(.CNTW(4), .TIMEOUT(TO)) dut4 (
        .clk(clk), .rst(rst), .phi2(phi2), .bus(ifb.slave),
        .err(err_b), .mulcnt(mc_b), .stallcnt(sc_b)
    );

    // reference model state
    int     st;
    int     wd;
    bit     merr;
    longint m32, s32, m4, s4;
    int     acnt;   // remaining ALU busy phi2 cycles
    bit     hang;   // ALU stuck busy
    bit     dword;  // length of the next issued multiply
    int     checks;
    int     failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic cyc(input bit r, input bit p, input bit v, input bit m,
                       input bit h, input bit f, input bit hd);
        bit busy, live, free, iss, stl;
        @(negedge clk);
        busy = (acnt > 0);
        rst = r; phi2 = p;
        ifa.ex_valid = v; ifa.ex_mul = m; ifa.ex_hilo_rd = h;
        ifa.ex_flush = f; ifa.ex_hold = hd; ifa.alubusy = busy;
        live = v && !f;
        free = (st == M_ID) || (st == M_RN && !busy);
        iss  = !r && p && free && live && m && !hd && !busy;
        stl  = !r && live && (m || h) && !free;
        #1;
        chk("alugo",     {63'd0, ifa.alugo},   {63'd0, iss});
        chk("exstall",   {63'd0, ifa.exstall}, {63'd0, stl});
        chk("alugo_c4",  {63'd0, ifb.alugo},   {63'd0, iss});
        chk("exstall_c4",{63'd0, ifb.exstall}, {63'd0, stl});
        @(posedge clk);
        if (r) begin
            st = M_SY; wd = 0; merr = 0; m32 = 0; s32 = 0; m4 = 0; s4 = 0;
        end else if (p) begin
            if (iss) begin m32 = sat(m32, 64'hFFFF_FFFF); m4 = sat(m4, 15); end
            if (stl) begin s32 = sat(s32, 64'hFFFF_FFFF); s4 = sat(s4, 15); end
            if (st == M_SY) begin
                if (!busy) begin st = M_ID; wd = 0; end
            end else if (st == M_ID) begin
                if (iss) begin st = M_RN; wd = 0; end
            end else begin
                if (busy) begin
                    wd++;
                    if (wd == TO) begin st = M_SY; merr = 1; wd = 0; end
                end else begin
                    st = iss ? M_RN : M_ID; wd = 0;
                end
            end
        end
        // ALU ignores rst: it finishes whatever it was doing.
        if (p) begin
            if (acnt > 0 && !hang) acnt--;
            if (iss) acnt = dword ? 7 : 4;
        end
        #1;
        chk("err",        {63'd0, err_a}, {63'd0, merr});
        chk("err_c4",     {63'd0, err_b}, {63'd0, merr});
        chk("mulcnt",     {32'd0, mc_a},  m32);
        chk("stallcnt",   {32'd0, sc_a},  s32);
        chk("mulcnt_c4",  {60'd0, mc_b},  m4);
        chk("stallcnt_c4",{60'd0, sc_b},  s4);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 1, 0, 0, 0, 0, 0);
    endtask

    // reset, let the ALU drain, then one cycle to leave SYNC
    task automatic reset_clean();
        hang = 0;
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && acnt > 0; i++) idle(1);
        idle(1);
    endtask

    initial begin
        checks = 0; failures = 0;
        st = M_SY; wd = 0; merr = 0; m32 = 0; s32 = 0; m4 = 0; s4 = 0;
        acnt = 3; hang = 0; dword = 0;
        rst = 1; phi2 = 0;
        ifa.ex_valid = 0; ifa.ex_mul = 0; ifa.ex_hilo_rd = 0;
        ifa.ex_flush = 0; ifa.ex_hold = 0; ifa.alubusy = 1;

        // power-up: reset while the ALU is still busy; MUL waits in SYNC
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("rst_mulcnt", {32'd0, mc_a}, 64'd0);
        chk("rst_err", {63'd0, err_a}, 64'd0);
        repeat (4) cyc(0, 1, 1, 1, 0, 0, 0);

        // word MUL then MFLO: 4 stall cycles
        reset_clean(); dword = 0;
        cyc(0, 1, 1, 1, 0, 0, 0);
        repeat (4) cyc(0, 1, 1, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 1, 0, 0);
        idle(1);
        chk("t1_mulcnt", {32'd0, mc_a}, 64'd1);
        chk("t1_stallcnt", {32'd0, sc_a}, 64'd4);

        // dword MUL followed by MUL: second issues at N+8
        reset_clean(); dword = 1;
        cyc(0, 1, 1, 1, 0, 0, 0);
        repeat (7) cyc(0, 1, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0);
        chk("t2_mulcnt", {32'd0, mc_a}, 64'd2);
        chk("t2_stallcnt", {32'd0, sc_a}, 64'd7);

        // flushed issue candidate, then flush mid-multiply
        reset_clean(); dword = 0;
        cyc(0, 1, 1, 1, 0, 1, 0);
        chk("t3_flush_mulcnt", {32'd0, mc_a}, 64'd0);
        cyc(0, 1, 1, 1, 0, 0, 0);
        idle(1);
        cyc(0, 1, 1, 1, 0, 1, 0);
        repeat (3) cyc(0, 1, 1, 0, 1, 0, 0);
        chk("t3_mulcnt", {32'd0, mc_a}, 64'd1);
        chk("t3_stallcnt", {32'd0, sc_a}, 64'd2);

        // held MUL retries; rst at N+2 of a dword MUL, MFHI after
        reset_clean(); dword = 1;
        cyc(0, 1, 1, 1, 0, 0, 1);
        cyc(0, 1, 1, 1, 0, 0, 0);
        idle(1);
        cyc(1, 1, 1, 1, 0, 0, 0);
        chk("t4_rst_mulcnt", {32'd0, mc_a}, 64'd0);
        chk("t4_rst_stallcnt", {32'd0, sc_a}, 64'd0);
        repeat (7) cyc(0, 1, 1, 0, 1, 0, 0);
        chk("t4_stallcnt", {32'd0, sc_a}, 64'd6);

        // watchdog: ALU stuck busy after an issue
        reset_clean(); dword = 0;
        hang = 1;
        cyc(0, 1, 1, 1, 0, 0, 0);
        idle(14);
        chk("t5_err_early", {63'd0, err_a}, 64'd0);
        idle(1);
        chk("t5_err_fire", {63'd0, err_a}, 64'd1);
        cyc(0, 1, 1, 0, 1, 0, 0);
        hang = 0;
        for (int i = 0; i < 20 && acnt > 0; i++) idle(1);
        repeat (3) cyc(0, 1, 1, 1, 0, 0, 0);
        chk("t5_err_sticky", {63'd0, err_a}, 64'd1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("t5_err_rst", {63'd0, err_a}, 64'd0);

        // saturation: 20 stalled phi2 cycles interleaved with phi2=0
        hang = 1; acnt = 1;
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, (i % 2) == 0, 1, 1, 0, 0, 0);
        chk("t6_stallcnt_c4", {60'd0, sc_b}, 64'd15);
        chk("t6_stallcnt", {32'd0, sc_a}, 64'd20);
        reset_clean();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            dword = $urandom_range(0, 1);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
